// File: rtl/stroke_detector.sv
// Flywheel stroke detector: times intervals between sensor rises and strobes
// entry into the drive (accelerating) and recovery (decelerating) phases.
module stroke_detector #(
    parameter int TICK_W       = 32,
    parameter int MIN_INTERVAL = 16,
    parameter int TIMEOUT      = 10_000_000,
    parameter int CONFIRM      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sensor,
    output logic              start_drive,
    output logic              start_recovery,
    output logic              on_drive,
    output logic              idle,
    output logic [TICK_W-1:0] last_interval
);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_RECOVERY} state_t;

    localparam logic [TICK_W-1:0] MIN_T  = TICK_W'(MIN_INTERVAL);
    localparam logic [TICK_W-1:0] TOUT_T = TICK_W'(TIMEOUT);
    localparam logic [3:0]        CONF_T = 4'(CONFIRM);

    state_t            state, state_nxt;
    logic              s1, s2, s3;
    logic [TICK_W-1:0] cnt, cnt_nxt;
    logic [TICK_W-1:0] prev, prev_nxt, li_nxt;
    logic              ref_valid, ref_valid_nxt;
    logic              prev_valid, prev_valid_nxt;
    logic [3:0]        acc_streak, acc_nxt, dec_streak, dec_nxt;
    logic              drive_nxt, rec_nxt;
    logic              rise, accept, at_limit;

    assign rise     = s2 & ~s3;
    assign accept   = rise & (~ref_valid | (cnt >= MIN_T));
    assign at_limit = (cnt == TOUT_T);
    assign on_drive = (state == S_DRIVE);
    assign idle     = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        ref_valid_nxt  = ref_valid;
        prev_valid_nxt = prev_valid;
        prev_nxt       = prev;
        li_nxt         = last_interval;
        acc_nxt        = acc_streak;
        dec_nxt        = dec_streak;
        drive_nxt      = 1'b0;
        rec_nxt        = 1'b0;
        cnt_nxt        = accept ? TICK_W'(1) : (at_limit ? cnt : cnt + TICK_W'(1));

        if (accept && at_limit) begin
            // A rise landing on the timeout cycle restarts measurement from it.
            state_nxt      = S_IDLE;
            ref_valid_nxt  = 1'b1;
            prev_valid_nxt = 1'b0;
            acc_nxt        = '0;
            dec_nxt        = '0;
        end else if (accept) begin
            if (!ref_valid) begin
                ref_valid_nxt = 1'b1;
            end else if (!prev_valid) begin
                prev_nxt       = cnt;
                li_nxt         = cnt;
                prev_valid_nxt = 1'b1;
            end else begin
                if (cnt < prev) begin
                    acc_nxt = (acc_streak >= CONF_T) ? CONF_T : acc_streak + 4'd1;
                    dec_nxt = '0;
                end else if (cnt > prev) begin
                    dec_nxt = (dec_streak >= CONF_T) ? CONF_T : dec_streak + 4'd1;
                    acc_nxt = '0;
                end
                prev_nxt = cnt;
                li_nxt   = cnt;
                if (state != S_DRIVE && acc_nxt == CONF_T) begin
                    state_nxt = S_DRIVE;
                    drive_nxt = 1'b1;
                    acc_nxt   = '0;
                    dec_nxt   = '0;
                end else if (state == S_DRIVE && dec_nxt == CONF_T) begin
                    state_nxt = S_RECOVERY;
                    rec_nxt   = 1'b1;
                    acc_nxt   = '0;
                    dec_nxt   = '0;
                end
            end
        end else if (at_limit) begin
            state_nxt      = S_IDLE;
            ref_valid_nxt  = 1'b0;
            prev_valid_nxt = 1'b0;
            acc_nxt        = '0;
            dec_nxt        = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1             <= 1'b0;
            s2             <= 1'b0;
            s3             <= 1'b0;
            cnt            <= '0;
            prev           <= '0;
            last_interval  <= '0;
            ref_valid      <= 1'b0;
            prev_valid     <= 1'b0;
            acc_streak     <= '0;
            dec_streak     <= '0;
            start_drive    <= 1'b0;
            start_recovery <= 1'b0;
        end else begin
            s1             <= sensor;
            s2             <= s1;
            s3             <= s2;
            cnt            <= cnt_nxt;
            prev           <= prev_nxt;
            last_interval  <= li_nxt;
            ref_valid      <= ref_valid_nxt;
            prev_valid     <= prev_valid_nxt;
            acc_streak     <= acc_nxt;
            dec_streak     <= dec_nxt;
            start_drive    <= drive_nxt;
            start_recovery <= rec_nxt;
        end
    end

endmodule
